// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: widths, ALU op codes
// and the arbiter FSM state encoding.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] ALU_AND     = 3'd0;
  localparam logic [OP_W-1:0] ALU_OR      = 3'd1;
  localparam logic [OP_W-1:0] ALU_NOR     = 3'd2;
  localparam logic [OP_W-1:0] ALU_XOR     = 3'd3;
  localparam logic [OP_W-1:0] ALU_ADD     = 3'd4;
  localparam logic [OP_W-1:0] ALU_SUB     = 3'd5;
  localparam logic [OP_W-1:0] ALU_SLT     = 3'd6;
  localparam logic [OP_W-1:0] ALU_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op != ALU_ILLEGAL;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone valid requester always wins, and under
// contention the requester named by ptr wins.
module rr_arb2
  import alu_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic ptr,
  input  logic enable,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (enable) begin
      if (valid0 && valid1) begin
        grant0 = ~ptr;
        grant1 = ptr;
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters: operands are
// registered toward the ALU for one EXEC cycle, the result comes back tagged.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err
);

  state_e              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                id_q, id_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_err_q, rsp_err_d;

  logic                accept_ok;
  logic                grant0, grant1;
  logic                accept;
  logic [OP_W-1:0]     acc_op;
  logic [DATA_W-1:0]   acc_a, acc_b;

  // A new op may enter when idle, or in the same cycle the pending response
  // is consumed; reset blocks any handshake on the reset cycle itself.
  assign accept_ok = !reset &&
                     ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

  rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ptr    (rr_ptr_q),
    .enable (accept_ok),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign acc_op     = grant1 ? req1_op : req0_op;
  assign acc_a      = grant1 ? req1_a  : req0_a;
  assign acc_b      = grant1 ? req1_b  : req0_b;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    alu_op_d   = '0;
    alu_a_d    = '0;
    alu_b_d    = '0;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      IDLE: state_d = IDLE;
      EXEC: begin
        state_d    = RESP;
        rsp_id_d   = id_q;
        rsp_data_d = op_is_legal(op_q) ? alu_res : '0;
        rsp_zero_d = (rsp_data_d == '0);
        rsp_err_d  = !op_is_legal(op_q);
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // ALU inputs are loaded on the accept edge so they are stable for the
    // whole EXEC cycle; an illegal op keeps the ALU inputs at zero.
    if (accept) begin
      state_d  = EXEC;
      rr_ptr_d = ~grant1;
      op_d     = acc_op;
      a_d      = acc_a;
      b_d      = acc_b;
      id_d     = grant1;
      if (op_is_legal(acc_op)) begin
        alu_op_d = acc_op;
        alu_a_d  = acc_a;
        alu_b_d  = acc_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic, every
// cycle compared against a transaction-level model of the arbiter.
module tb_alu_share_arbiter;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] alu_a, alu_b, alu_res, rsp_data;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  op_t q0[$];
  op_t q1[$];
  bit  present0, present1;
  int  gap_pct, rdy_pct;

  bit  m_has, m_ptr, m_id, m_clean, m_g0, m_g1, m_hs;
  int  m_age;
  op_t m_txn;

  int          log_cyc[$];
  bit          log_id[$];
  logic [31:0] log_data[$];
  bit          log_zero[$];
  bit          log_err[$];
  bit          grant_log[$];

  alu_share_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_res    (alu_res),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a | b);
      3'd3: return a ^ b;
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // The shared ALU itself, reacting to whatever the arbiter drives.
  assign alu_res = ref_alu(alu_op, alu_a, alu_b);

  function automatic logic [31:0] rnd32();
    case ($urandom_range(3))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.op = 3'($urandom_range(7));
    o.a  = rnd32();
    o.b  = ($urandom_range(4) == 0) ? o.a : rnd32();
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit rdy_force, input bit rdy_val);
    reset = rst;
    if (!present0 && q0.size() > 0) present0 = ($urandom_range(99) >= gap_pct);
    if (!present1 && q1.size() > 0) present1 = ($urandom_range(99) >= gap_pct);
    req0_valid = present0;
    req1_valid = present1;
    if (present0) {req0_op, req0_a, req0_b} = q0[0];
    else {req0_op, req0_a, req0_b} = {3'($urandom), $urandom, $urandom};
    if (present1) {req1_op, req1_a, req1_b} = q1[0];
    else {req1_op, req1_a, req1_b} = {3'($urandom), $urandom, $urandom};
    rsp_ready = rdy_force ? rdy_val : ($urandom_range(99) < rdy_pct);
  endtask

  // Model view: an accepted op drives the ALU in the cycle after acceptance
  // and is offered as a response from the cycle after that until consumed.
  task automatic checkOutput();
    logic [2:0]  e_op;
    logic [31:0] e_a, e_b, e_res;
    bit          e_valid, can;
    e_op = 3'd0;
    e_a  = 32'd0;
    e_b  = 32'd0;
    if (m_has && m_age == 1 && m_txn.op != 3'd7) begin
      e_op = m_txn.op;
      e_a  = m_txn.a;
      e_b  = m_txn.b;
    end
    e_valid = m_has && m_age >= 2;
    can  = !reset && (!m_has || (e_valid && rsp_ready));
    m_g0 = can && req0_valid && (!req1_valid || !m_ptr);
    m_g1 = can && req1_valid && (!req0_valid || m_ptr);
    m_hs = !reset && e_valid && rsp_ready;
    check("alu_op", 32'(alu_op), 32'(e_op));
    check("alu_a", alu_a, e_a);
    check("alu_b", alu_b, e_b);
    check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
    check("req0_ready", 32'(req0_ready), 32'(m_g0));
    check("req1_ready", 32'(req1_ready), 32'(m_g1));
    if (e_valid) begin
      e_res = ref_alu(m_txn.op, m_txn.a, m_txn.b);
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_data", rsp_data, e_res);
      check("rsp_zero", 32'(rsp_zero), 32'(e_res == 32'd0));
      check("rsp_err", 32'(rsp_err), 32'(m_txn.op == 3'd7));
    end else if (m_clean) begin
      check("rsp_id_rst", 32'(rsp_id), 32'd0);
      check("rsp_data_rst", rsp_data, 32'd0);
      check("rsp_zero_rst", 32'(rsp_zero), 32'd0);
      check("rsp_err_rst", 32'(rsp_err), 32'd0);
    end
    if (rsp_valid && rsp_ready && !reset) begin
      log_cyc.push_back(cyc);
      log_id.push_back(rsp_id);
      log_data.push_back(rsp_data);
      log_zero.push_back(rsp_zero);
      log_err.push_back(rsp_err);
    end
    if (req0_ready) grant_log.push_back(1'b0);
    if (req1_ready) grant_log.push_back(1'b1);
  endtask

  task automatic step();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    if (reset) begin
      m_has   = 1'b0;
      m_ptr   = 1'b0;
      m_clean = 1'b1;
    end else begin
      if (m_hs) m_has = 1'b0;
      if (m_g0 || m_g1) begin
        m_txn = m_g1 ? op_t'{req1_op, req1_a, req1_b} : op_t'{req0_op, req0_a, req0_b};
        m_id  = m_g1;
        m_ptr = !m_g1;
        m_has = 1'b1;
        m_age = 1;
      end else if (m_has) begin
        m_age++;
      end
      if (m_has && m_age >= 2) m_clean = 1'b0;
    end
    if (m_g0) begin void'(q0.pop_front()); present0 = 1'b0; end
    if (m_g1) begin void'(q1.pop_front()); present1 = 1'b0; end
    cyc++;
    #1;
  endtask

  task automatic run(input int n, input bit rst, input bit rdy_force, input bit rdy_val);
    for (int i = 0; i < n; i++) begin
      applyStimulus(rst, rdy_force, rdy_val);
      step();
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    check({tag, "_alu_a"}, alu_a, 32'd0);
    check({tag, "_alu_b"}, alu_b, 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_rsp_flags"}, {29'd0, rsp_id, rsp_zero, rsp_err}, 32'd0);
  endtask

  initial begin
    int   base, gbase;
    op_t  b2b[$];
    gap_pct  = 0;
    rdy_pct  = 100;
    present0 = 1'b0;
    present1 = 1'b0;
    m_has    = 1'b0;
    m_ptr    = 1'b0;
    m_clean  = 1'b1;
    m_age    = 0;
    m_txn    = '0;
    m_id     = 1'b0;

    run(2, 1'b1, 1'b1, 1'b1);
    check_idle_zero("reset");

    // NOR from requester 0 alone
    q0.push_back(op_t'{3'd2, 32'hF0F0_0000, 32'h0000_00FF});
    run(1, 1'b0, 1'b1, 1'b1);
    check("nor_exec_alu_op", 32'(alu_op), 32'd2);
    check("nor_exec_alu_a", alu_a, 32'hF0F0_0000);
    run(1, 1'b0, 1'b1, 1'b1);
    check("nor_rsp_valid", 32'(rsp_valid), 32'd1);
    check("nor_rsp_data", rsp_data, 32'h0F0F_FF00);
    check("nor_rsp_flags", {29'd0, rsp_id, rsp_zero, rsp_err}, 32'd0);
    run(2, 1'b0, 1'b1, 1'b1);

    // Contention straight after reset, then four held requests alternate
    run(2, 1'b1, 1'b1, 1'b1);
    base  = log_data.size();
    gbase = grant_log.size();
    q0.push_back(op_t'{3'd4, 32'd5, 32'd7});
    q1.push_back(op_t'{3'd5, 32'd9, 32'd9});
    run(6, 1'b0, 1'b1, 1'b1);
    check("cont_nrsp", 32'(log_data.size() - base), 32'd2);
    if (log_data.size() >= base + 2) begin
      check("cont_first_data", log_data[base], 32'd12);
      check("cont_first_id", 32'(log_id[base]), 32'd0);
      check("cont_second_data", log_data[base+1], 32'd0);
      check("cont_second_id", 32'(log_id[base+1]), 32'd1);
      check("cont_second_zero", 32'(log_zero[base+1]), 32'd1);
    end
    gbase = grant_log.size();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(rnd_op());
      q1.push_back(rnd_op());
    end
    run(10, 1'b0, 1'b1, 1'b1);
    check("alt_ngrant", 32'(grant_log.size() - gbase), 32'd4);
    if (grant_log.size() >= gbase + 4)
      check("alt_order", {28'd0, grant_log[gbase], grant_log[gbase+1],
                          grant_log[gbase+2], grant_log[gbase+3]}, 32'b0101);

    // Backpressure: response held for five cycles, then handshake with req1 waiting
    q0.push_back(op_t'{3'd4, 32'd100, 32'd23});
    run(2, 1'b0, 1'b1, 1'b1);
    q1.push_back(op_t'{3'd3, 32'hAAAA_0000, 32'h0000_5555});
    gbase = grant_log.size();
    run(5, 1'b0, 1'b1, 1'b0);
    check("bp_rsp_data", rsp_data, 32'd123);
    check("bp_no_grant", 32'(grant_log.size() - gbase), 32'd0);
    base = log_data.size();
    run(1, 1'b0, 1'b1, 1'b1);
    check("bp_grant_now", 32'(grant_log.size() - gbase), 32'd1);
    if (grant_log.size() > gbase) check("bp_grant_id", 32'(grant_log[gbase]), 32'd1);
    run(2, 1'b0, 1'b1, 1'b1);
    check("bp_nrsp", 32'(log_data.size() - base), 32'd2);
    if (log_data.size() >= base + 2) begin
      check("bp_next_data", log_data[base+1], 32'hAAAA_5555);
      check("bp_next_gap", 32'(log_cyc[base+1] - log_cyc[base]), 32'd2);
    end
    run(2, 1'b0, 1'b1, 1'b1);

    // Signed SLT and the illegal op code
    base = log_data.size();
    q0.push_back(op_t'{3'd6, 32'hFFFF_FFFF, 32'd1});
    q0.push_back(op_t'{3'd7, 32'h1234_5678, 32'h8765_4321});
    run(6, 1'b0, 1'b1, 1'b1);
    check("slt_nrsp", 32'(log_data.size() - base), 32'd2);
    if (log_data.size() >= base + 2) begin
      check("slt_data", log_data[base], 32'd1);
      check("ill_data", log_data[base+1], 32'd0);
      check("ill_err", 32'(log_err[base+1]), 32'd1);
      check("ill_zero", 32'(log_zero[base+1]), 32'd1);
    end

    // Reset while an op is in EXEC
    base = log_data.size();
    q0.push_back(op_t'{3'd4, 32'd3, 32'd4});
    run(1, 1'b0, 1'b1, 1'b1);
    check("rst_mid_exec_alu_op", 32'(alu_op), 32'd4);
    run(1, 1'b1, 1'b1, 1'b1);
    check_idle_zero("rst_mid");
    run(4, 1'b0, 1'b1, 1'b1);
    check("rst_mid_no_stale", 32'(log_data.size() - base), 32'd0);

    // Back-to-back stream from requester 0
    base = log_data.size();
    for (int i = 0; i < 6; i++) begin
      b2b.push_back(rnd_op());
      q0.push_back(b2b[i]);
    end
    run(14, 1'b0, 1'b1, 1'b1);
    check("b2b_nrsp", 32'(log_data.size() - base), 32'd6);
    if (log_data.size() >= base + 6) begin
      for (int i = 0; i < 6; i++) begin
        check("b2b_order", log_data[base+i], ref_alu(b2b[i].op, b2b[i].a, b2b[i].b));
        if (i > 0) check("b2b_rate", 32'(log_cyc[base+i] - log_cyc[base+i-1]), 32'd2);
      end
    end

    // Random traffic with gaps, backpressure and occasional resets
    gap_pct = 30;
    rdy_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      if (q0.size() < 2) q0.push_back(rnd_op());
      if (q1.size() < 2) q1.push_back(rnd_op());
      applyStimulus($urandom_range(299) == 0, 1'b0, 1'b0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
